// File: rtl/lpc_cycle_streamer_pkg.sv
// Shared constants for the LPC cycle-record streamer: record field layout,
// cycle-type codes and the frame sync byte.
package lpc_cycle_streamer_pkg;

    localparam logic [1:0] LPC_CYC_WR      = 2'b01;
    localparam logic [1:0] LPC_CYC_RD      = 2'b11;
    localparam logic [7:0] LPC_STREAM_SYNC = 8'hA5;

    // Record layout: [27:12] address, [11:4] data, [1:0] cycle type
    localparam int LPC_REC_ADDR_LSB = 12;
    localparam int LPC_REC_ADDR_W   = 16;
    localparam int LPC_REC_DATA_LSB = 4;
    localparam int LPC_REC_DATA_W   = 8;
    localparam int LPC_REC_TYPE_LSB = 0;
    localparam int LPC_REC_TYPE_W   = 2;

    function automatic logic rec_type_ok(input logic [1:0] cyc_type);
        return (cyc_type == LPC_CYC_WR) || (cyc_type == LPC_CYC_RD);
    endfunction

endpackage

// File: rtl/lpc_sync_fifo.sv
// Generic single-clock FIFO with extra-MSB pointers. Read data is registered
// on the read strobe; a write while full is accepted only alongside a read.
module lpc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     nrst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level_o = wr_ptr - rd_ptr;
    assign do_rd   = rd_en_i && !empty_o;
    assign do_wr   = wr_en_i && (!full_o || do_rd);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_data_o <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rd_data_o <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/lpc_cycle_streamer.sv
// Buffers decoded LPC I/O cycle records and streams each one as a 5-byte
// frame (sync byte, then record MSB first) over valid/ready.
//
// state   | meaning
// ST_IDLE | no frame in flight, waiting for a buffered record
// ST_HDR  | sync byte presented
// ST_B3   | record[31:24] presented
// ST_B2   | record[23:16] presented
// ST_B1   | record[15:8] presented
// ST_B0   | record[7:0] presented; next frame may follow without a bubble
module lpc_cycle_streamer
    import lpc_cycle_streamer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE  = LPC_STREAM_SYNC
) (
    input  logic                          clk_i,
    input  logic                          nrst_i,
    input  logic [31:0]                   tdata_i,
    input  logic                          ready_i,
    output logic [7:0]                    m_tdata_o,
    output logic                          m_tvalid_o,
    input  logic                          m_tready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o,
    output logic [7:0]                    drop_cnt_o,
    input  logic                          clr_ovf_i
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_B3, ST_B2, ST_B1, ST_B0
    } st_e;

    st_e         state, state_nxt;
    logic [7:0]  tdata_nxt;
    logic        tvalid_nxt;
    logic        pop;
    logic        accept;
    logic        ready_q;
    logic        rec_ok;
    logic        push;
    logic        drop;
    logic        full;
    logic        empty;
    logic [31:0] rec;

    assign rec_ok = ready_i && !ready_q && rec_type_ok(tdata_i[LPC_REC_TYPE_LSB +: LPC_REC_TYPE_W]);
    assign push   = rec_ok && (!full || pop);
    assign drop   = rec_ok && full && !pop;
    assign accept = m_tvalid_o && m_tready_i;

    lpc_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .nrst_i    (nrst_i),
        .wr_en_i   (push),
        .wr_data_i (tdata_i),
        .rd_en_i   (pop),
        .rd_data_o (rec),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (fifo_level_o)
    );

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            ready_q    <= 1'b0;
            state      <= ST_IDLE;
            m_tdata_o  <= '0;
            m_tvalid_o <= 1'b0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            ready_q    <= ready_i;
            state      <= state_nxt;
            m_tdata_o  <= tdata_nxt;
            m_tvalid_o <= tvalid_nxt;
            // A clear coinciding with a drop still records that drop
            if (clr_ovf_i) begin
                overflow_o <= drop;
                drop_cnt_o <= drop ? 8'd1 : 8'd0;
            end else if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
            end
        end
    end

    // The popped record lands in the FIFO read register one edge later,
    // while the sync byte is on the bus, and holds until the next pop.
    always_comb begin
        state_nxt  = state;
        tdata_nxt  = m_tdata_o;
        tvalid_nxt = m_tvalid_o;
        pop        = 1'b0;
        case (state)
            ST_IDLE: if (!empty) begin
                pop        = 1'b1;
                tdata_nxt  = SYNC_BYTE;
                tvalid_nxt = 1'b1;
                state_nxt  = ST_HDR;
            end
            ST_HDR: if (accept) begin
                tdata_nxt = rec[31:24];
                state_nxt = ST_B3;
            end
            ST_B3: if (accept) begin
                tdata_nxt = rec[23:16];
                state_nxt = ST_B2;
            end
            ST_B2: if (accept) begin
                tdata_nxt = rec[15:8];
                state_nxt = ST_B1;
            end
            ST_B1: if (accept) begin
                tdata_nxt = rec[7:0];
                state_nxt = ST_B0;
            end
            ST_B0: if (accept) begin
                if (!empty) begin
                    pop       = 1'b1;
                    tdata_nxt = SYNC_BYTE;
                    state_nxt = ST_HDR;
                end else begin
                    tvalid_nxt = 1'b0;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                tvalid_nxt = 1'b0;
                state_nxt  = ST_IDLE;
            end
        endcase
    end

endmodule
